// File: rtl/pulse_pacer_pkg.sv
// Shared constants and state encoding for the pulse pacer.
package pulse_pacer_pkg;

  localparam int unsigned GAP_CNT_W = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT
  } state_t;

endpackage

// File: rtl/pulse_pacer.sv
// Source-domain event pacer: accepts events at any rate, counts them in a
// saturating pending counter and re-emits them as single-cycle pulses spaced
// at least GAP clocks apart so a toggle synchronizer never misses one.
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int unsigned GAP   = 6,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             evt_in,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0]     PEND_MAX = {CNT_W{1'b1}};
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP - 1);

  state_t               state;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 fire_c;
  logic                 drop_c;

  // A pulse is launched whenever the spacing window has closed and work is queued.
  assign fire_c = (state == S_IDLE) && (pending != '0);

  // An event is lost only when the counter is full and nothing drains this edge.
  assign drop_c = evt_in && !fire_c && (pending == PEND_MAX);

  assign busy = (state != S_IDLE) || (pending != '0);

  // Pacing FSM with gap counter and registered pulse output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      pulse_out <= 1'b0;
    end else if (state == S_IDLE) begin
      pulse_out <= fire_c;
      if (fire_c) begin
        gap_cnt <= GAP_LOAD;
        state   <= S_WAIT;
      end
    end else begin
      pulse_out <= 1'b0;
      if (gap_cnt == GAP_CNT_W'(1)) begin
        state   <= S_IDLE;
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
      end
    end
  end

  // Saturating pending counter: simultaneous accept and emit cancel out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else if (evt_in && !fire_c) begin
      if (pending != PEND_MAX) begin
        pending <= pending + CNT_W'(1);
      end
    end else if (fire_c && !evt_in) begin
      pending <= pending - CNT_W'(1);
    end
  end

  // Sticky overflow flag; a new drop takes priority over a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_pacer.sv
// Bench for pulse_pacer: two instances (GAP=6 and GAP=2) share stimulus and
// are compared every cycle against a reference model that tracks pending
// events and the number of edges since the last emitted pulse.
module tb_pulse_pacer;

  localparam int unsigned CNT_W = 4;
  localparam int          PMAX  = 15;

  logic clk;
  logic rstn;
  logic evt_in;
  logic ovf_clr;

  logic             po_o  [2];
  logic [CNT_W-1:0] pnd_o [2];
  logic             ovf_o [2];
  logic             bsy_o [2];

  int gaps [2] = '{6, 2};

  // Reference model state
  int m_pend  [2];
  int m_since [2];
  int m_ovf   [2];
  int m_pulse [2];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  pulse_pacer #(.GAP(6), .CNT_W(CNT_W)) u_dut_g6 (
    .clk       (clk),
    .rstn      (rstn),
    .evt_in    (evt_in),
    .ovf_clr   (ovf_clr),
    .pulse_out (po_o[0]),
    .pending   (pnd_o[0]),
    .overflow  (ovf_o[0]),
    .busy      (bsy_o[0])
  );

  pulse_pacer #(.GAP(2), .CNT_W(CNT_W)) u_dut_g2 (
    .clk       (clk),
    .rstn      (rstn),
    .evt_in    (evt_in),
    .ovf_clr   (ovf_clr),
    .pulse_out (po_o[1]),
    .pending   (pnd_o[1]),
    .overflow  (ovf_o[1]),
    .busy      (bsy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i]  = 0;
      m_since[i] = 255;
      m_ovf[i]   = 0;
      m_pulse[i] = 0;
    end
  endtask

  // One clock edge of the behavioural rules: emit when queued work exists and
  // at least GAP edges have passed since the previous emission.
  task automatic model_edge(input int i, input bit e, input bit c);
    bit fire;
    bit drop;
    fire = (m_pend[i] > 0) && (m_since[i] >= gaps[i] - 1);
    drop = e && !fire && (m_pend[i] == PMAX);
    if (e && !fire && !drop) m_pend[i]++;
    else if (fire && !e)     m_pend[i]--;
    if (drop)      m_ovf[i] = 1;
    else if (c)    m_ovf[i] = 0;
    m_pulse[i] = fire ? 1 : 0;
    if (fire)                m_since[i] = 0;
    else if (m_since[i] < 255) m_since[i]++;
  endtask

  task automatic compare_all();
    int exp_busy;
    for (int i = 0; i < 2; i++) begin
      exp_busy = ((m_since[i] < gaps[i] - 1) || (m_pend[i] != 0)) ? 1 : 0;
      chk($sformatf("g%0d_pulse", gaps[i]),    int'(po_o[i]),  m_pulse[i]);
      chk($sformatf("g%0d_pending", gaps[i]),  int'(pnd_o[i]), m_pend[i]);
      chk($sformatf("g%0d_overflow", gaps[i]), int'(ovf_o[i]), m_ovf[i]);
      chk($sformatf("g%0d_busy", gaps[i]),     int'(bsy_o[i]), exp_busy);
    end
  endtask

  task automatic step(input bit e, input bit c);
    @(negedge clk);
    evt_in  = e;
    ovf_clr = c;
    @(posedge clk);
    #1;
    edge_n++;
    for (int i = 0; i < 2; i++) model_edge(i, e, c);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_g%0d_pulse", tag, gaps[i]),    int'(po_o[i]),  0);
      chk($sformatf("%s_g%0d_pending", tag, gaps[i]),  int'(pnd_o[i]), 0);
      chk($sformatf("%s_g%0d_overflow", tag, gaps[i]), int'(ovf_o[i]), 0);
      chk($sformatf("%s_g%0d_busy", tag, gaps[i]),     int'(bsy_o[i]), 0);
    end
  endtask

  int pulse_edges [$];
  int peak;
  int k0;
  int prob;

  initial begin
    rstn    = 1'b0;
    evt_in  = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Single event after quiet period
    repeat (9) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Burst of 5: GAP=6 pulses must land on fixed edge offsets
    pulse_edges.delete();
    peak = 0;
    k0   = edge_n + 1;
    for (int n = 0; n < 40; n++) begin
      step(n < 5, 1'b0);
      if (po_o[0]) pulse_edges.push_back(edge_n - k0);
      if (int'(pnd_o[0]) > peak) peak = int'(pnd_o[0]);
    end
    chk("burst_pulse_count", pulse_edges.size(), 5);
    for (int n = 0; n < pulse_edges.size() && n < 5; n++)
      chk($sformatf("burst_pulse_%0d_offset", n), pulse_edges[n], 1 + 6 * n);
    chk("burst_peak_pending", peak, 4);
    chk("burst_overflow", int'(ovf_o[0]), 0);

    // Saturation with a clear colliding with drops, then drain
    peak = 0;
    for (int n = 0; n < 25; n++) begin
      step(1'b1, n == 22);
      if (int'(pnd_o[0]) > peak) peak = int'(pnd_o[0]);
    end
    chk("sat_peak_pending", peak, PMAX);
    chk("sat_overflow_set", int'(ovf_o[0]), 1);
    repeat (100) step(1'b0, 1'b0);
    chk("sat_overflow_sticky", int'(ovf_o[0]), 1);
    step(1'b0, 1'b1);
    chk("clr_alone", int'(ovf_o[0]), 0);

    // Reset while waiting with events queued
    repeat (4) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    chk("pre_reset_pending", int'(pnd_o[0]), 3);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) step(1'b0, 1'b0);

    // Randomized traffic at varying densities
    for (int blk = 0; blk < 15; blk++) begin
      prob = int'($urandom_range(0, 100));
      for (int n = 0; n < 200; n++)
        step(int'($urandom_range(0, 99)) < prob, ($urandom_range(0, 39) == 0));
    end
    repeat (120) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
